// File: rtl/pc_fetch_unit.sv
// PC/fetch front end: registered fetch request with PC_STEP advance and redirects; first valid 2 edges after reset release.
// Request holds stable while fetch_ready=0 (redirects stored as pending). Optional accepted-fetch counter under `FETCH_CNT_EN.
module pc_fetch_unit #(
  parameter int unsigned          BITSIZE  = 32,
  parameter logic [BITSIZE-1:0]   RESET_PC = 32'h00000000,
  parameter int unsigned          PC_STEP  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redir_valid,
  input  logic [BITSIZE-1:0] redir_pc,
  output logic               fetch_valid,
  input  logic               fetch_ready,
  output logic [BITSIZE-1:0] fetch_pc,
  output logic               misalign_err
`ifdef FETCH_CNT_EN
  ,
  output logic [15:0]        fetch_count
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    STALLED = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               armed_q, armed_d;
  logic [BITSIZE-1:0] pc_q, pc_d;
  logic               pend_vld_q, pend_vld_d;
  logic [BITSIZE-1:0] pend_pc_q, pend_pc_d;
  logic               misalign_q, misalign_d;

  logic accept;
  logic redir_ok;
  logic redir_bad;

  assign accept    = (state_q == FETCH) && fetch_ready;
  assign redir_ok  = redir_valid && (redir_pc[1:0] == 2'b00);
  assign redir_bad = redir_valid && (redir_pc[1:0] != 2'b00);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; armed_q keeps IDLE for one full cycle after reset release
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (armed_q) begin
          state_d = stall ? STALLED : FETCH;
        end
      end
      FETCH: begin
        if (fetch_ready && stall) begin
          state_d = STALLED;
        end
      end
      STALLED: begin
        if (!stall) begin
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: decoded from the state flop only, so no input reaches an output
  always_comb begin
    fetch_valid = (state_q == FETCH);
  end

  // PC, pending-redirect and sticky error datapath
  always_comb begin
    armed_d    = 1'b1;
    pc_d       = pc_q;
    pend_vld_d = pend_vld_q;
    pend_pc_d  = pend_pc_q;
    misalign_d = misalign_q | redir_bad;

    if (state_q == FETCH) begin
      if (accept) begin
        pend_vld_d = 1'b0;
        if (redir_ok) begin
          pc_d = redir_pc;
        end else if (pend_vld_q) begin
          pc_d = pend_pc_q;
        end else begin
          pc_d = pc_q + BITSIZE'(PC_STEP);
        end
      end else if (redir_ok) begin
        pend_vld_d = 1'b1;
        pend_pc_d  = redir_pc;
      end
    end else if (redir_ok) begin
      pc_d       = redir_pc;
      pend_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_q    <= 1'b0;
      pc_q       <= RESET_PC;
      pend_vld_q <= 1'b0;
      pend_pc_q  <= '0;
      misalign_q <= 1'b0;
    end else begin
      armed_q    <= armed_d;
      pc_q       <= pc_d;
      pend_vld_q <= pend_vld_d;
      pend_pc_q  <= pend_pc_d;
      misalign_q <= misalign_d;
    end
  end

  assign fetch_pc     = pc_q;
  assign misalign_err = misalign_q;

`ifdef FETCH_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign fetch_count = cnt_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: inputs change 1ns after each rising edge, outputs are checked at the same point.
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_pc;
  logic        misalign_err;
`ifdef FETCH_CNT_EN
  logic [15:0] fetch_count;
`endif

  int checks = 0;
  int errors = 0;

  pc_fetch_unit #(
    .BITSIZE (32),
    .RESET_PC(32'h00000000),
    .PC_STEP (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .fetch_valid (fetch_valid),
    .fetch_ready (fetch_ready),
    .fetch_pc    (fetch_pc),
    .misalign_err(misalign_err)
`ifdef FETCH_CNT_EN
    ,
    .fetch_count (fetch_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_fetch(input string tag, input logic vld, input logic [31:0] pc);
    chk({tag, "_vld"}, {31'd0, fetch_valid}, {31'd0, vld});
    chk({tag, "_pc"}, fetch_pc, pc);
  endtask

  initial begin
    rst         = 1'b1;
    stall       = 1'b0;
    redir_valid = 1'b0;
    redir_pc    = 32'h0;
    fetch_ready = 1'b1;

    // Reset state
    step();
    step();
    chk_fetch("rst", 1'b0, 32'h0);
    chk("rst_misalign", {31'd0, misalign_err}, 32'd0);
`ifdef FETCH_CNT_EN
    chk("rst_cnt", {16'd0, fetch_count}, 32'd0);
`endif

    // Latency: one full IDLE cycle, valid on the second edge
    rst = 1'b0;
    step();
    chk_fetch("idle", 1'b0, 32'h0);
    step();
    chk_fetch("first", 1'b1, 32'h0);
    step();
    chk_fetch("seq1", 1'b1, 32'h4);
    step();
    chk_fetch("seq2", 1'b1, 32'h8);

    // Blocked at 0x8; two redirects, newest wins
    fetch_ready = 1'b0;
    redir_valid = 1'b1;
    redir_pc    = 32'h100;
    step();
    chk_fetch("blk1", 1'b1, 32'h8);
    redir_pc = 32'h200;
    step();
    chk_fetch("blk2", 1'b1, 32'h8);
    redir_valid = 1'b0;
    fetch_ready = 1'b1;
    step();
    chk_fetch("pend", 1'b1, 32'h200);
    step();
    chk_fetch("pend_seq", 1'b1, 32'h204);

    // Same-cycle redirect beats pending redirect
    redir_valid = 1'b1;
    redir_pc    = 32'h10;
    step();
    chk_fetch("to10", 1'b1, 32'h10);
    fetch_ready = 1'b0;
    redir_pc    = 32'h80;
    step();
    chk_fetch("hold10", 1'b1, 32'h10);
    fetch_ready = 1'b1;
    redir_pc    = 32'h40;
    step();
    chk_fetch("prio", 1'b1, 32'h40);
    redir_valid = 1'b0;
    step();
    chk_fetch("pend_clr", 1'b1, 32'h44);

    // Misaligned redirect ignored, sticky error
    redir_valid = 1'b1;
    redir_pc    = 32'h20;
    step();
    chk_fetch("to20", 1'b1, 32'h20);
    chk("mis_pre", {31'd0, misalign_err}, 32'd0);
    redir_pc = 32'h102;
    step();
    chk_fetch("mis_ign", 1'b1, 32'h24);
    chk("mis_set", {31'd0, misalign_err}, 32'd1);
    redir_valid = 1'b0;
    step();
    chk_fetch("mis_seq", 1'b1, 32'h28);
    chk("mis_sticky", {31'd0, misalign_err}, 32'd1);

    // Stall while blocked at 0x30
    redir_valid = 1'b1;
    redir_pc    = 32'h30;
    step();
    chk_fetch("to30", 1'b1, 32'h30);
    redir_valid = 1'b0;
    fetch_ready = 1'b0;
    stall       = 1'b1;
    step();
    chk_fetch("stblk1", 1'b1, 32'h30);
    step();
    chk_fetch("stblk2", 1'b1, 32'h30);
    fetch_ready = 1'b1;
    step();
    chk_fetch("stalled", 1'b0, 32'h34);
    stall = 1'b0;
    step();
    chk_fetch("unstall", 1'b1, 32'h34);

    // Wrap-around
    redir_valid = 1'b1;
    redir_pc    = 32'hFFFF_FFFC;
    step();
    chk_fetch("top", 1'b1, 32'hFFFF_FFFC);
    redir_valid = 1'b0;
    step();
    chk_fetch("wrap", 1'b1, 32'h0);
    step();
    chk_fetch("wrap4", 1'b1, 32'h4);
`ifdef FETCH_CNT_EN
    chk("cnt", {16'd0, fetch_count}, 32'd15);
`endif

    // Reset asserted mid-handshake
    fetch_ready = 1'b0;
    step();
    chk_fetch("preblk", 1'b1, 32'h4);
    #2;
    rst = 1'b1;
    #1;
    chk_fetch("async_rst", 1'b0, 32'h0);
    chk("async_mis", {31'd0, misalign_err}, 32'd0);
`ifdef FETCH_CNT_EN
    chk("async_cnt", {16'd0, fetch_count}, 32'd0);
`endif
    step();
    rst         = 1'b0;
    fetch_ready = 1'b1;
    step();
    chk_fetch("re_idle", 1'b0, 32'h0);
    step();
    chk_fetch("re_first", 1'b1, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Sequential PC/fetch front end; consumes the next-PC redirect produced by branch resolution and drives instruction-memory fetch requests.
- Holds the architectural PC register.
- Issues one fetch address per accepted valid/ready handshake and advances sequentially by PC_STEP.
- Applies branch/jump redirects without ever violating handshake stability.

Parameters:
- BITSIZE, 32, PC / address width.
- RESET_PC, 32'h00000000, PC value loaded on reset.
- PC_STEP, 4, sequential increment in bytes.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  hazard stall; suppresses new fetch requests.
- redir_valid  input  1  redirect request, one cycle per request.
- redir_pc  input  BITSIZE  redirect target; sampled when redir_valid=1.
- fetch_valid  output  1  fetch request valid.
- fetch_ready  input  1  instruction memory accepts request.
- fetch_pc  output  BITSIZE  fetch address; equals the PC register.
- misalign_err  output  1  sticky flag: a redirect was dropped because its target was misaligned.
- fetch_count  output  16  accepted-fetch counter; present only with FETCH_CNT_EN.

Behaviour:
- Reset is asynchronous and active-high, and is named rst. The clock is clk.
- Reset values: fetch_pc=RESET_PC, fetch_valid=0, misalign_err=0, pending redirect cleared, state=IDLE, fetch_count=0.
- Reset asserted mid-handshake drops fetch_valid immediately. No completion is owed.
- All outputs are registered; no combinational path from any input to any output.
- States:
  - IDLE: fetch_valid=0. Occupied for exactly one cycle after reset release. Next state is FETCH if stall=0, else STALLED.
  - FETCH: fetch_valid=1.
  - STALLED: fetch_valid=0. Returns to FETCH the cycle after stall=0 is sampled.
- Handshake: a fetch is accepted on a rising edge where fetch_valid && fetch_ready.
  - While fetch_valid=1 && fetch_ready=0, fetch_pc and fetch_valid must hold stable.
- On acceptance, next PC is selected in this priority order:
  1. redir_pc, if redir_valid=1 in the same cycle;
  2. else the pending redirect target, if one is pending;
  3. else fetch_pc+PC_STEP.
  The pending redirect is cleared on acceptance.
- Redirect while fetch_valid=1 && fetch_ready=0: target stored as pending. A later redirect before acceptance overwrites it (newest wins).
- Redirect while fetch_valid=0 (IDLE or STALLED): fetch_pc <= redir_pc at the next edge. Any pending redirect is discarded.
- Stall:
  - stall=1 in FETCH with no outstanding request (ready=1 or the accept cycle): move to STALLED at the next edge, and fetch_valid=0.
  - stall=1 while the request is blocked (valid=1, ready=0): stay in FETCH until acceptance, then go to STALLED. The PC still advances or redirects on that acceptance.
- Misalignment: redir_pc[1:0]!=2'b00 with redir_valid=1 means the redirect is ignored entirely (no PC change, no pending update) and misalign_err is set. misalign_err is cleared only by rst.
- Arithmetic: PC increment is modulo 2^BITSIZE. 32'hFFFFFFFC+4 wraps to 32'h00000000 with no flag.
- Latency: first fetch_valid=1 appears 2 edges after reset release (one cycle in IDLE). With ready held high there is one accepted fetch per cycle.

Optional Feature:
- Macro FETCH_CNT_EN.
- Defined:
  - fetch_count port exists and increments by 1 on each accepted fetch, wrapping 16'hFFFF to 0.
  - Reset sets it to 0.
  - Redirects and stall do not affect it.
- Undefined: no fetch_count port and no counter logic. All other behaviour is identical.

Test Plan:
- Reset then ready=1, stall=0 -> fetch_valid rises 2 edges after reset release. Accepted addresses are 0x0, 0x4, 0x8, 0xC on consecutive cycles.
- ready=0 holding fetch_pc=0x8; redirect 0x100, then redirect 0x200, both while blocked; then ready=1 -> fetch_pc stable at 0x8 throughout. After acceptance fetch_pc=0x200, then 0x204.
- Redirect to 0x40 in the same cycle as acceptance at 0x10, with a pending redirect to 0x80 -> next fetch_pc=0x40.
- redir_pc=0x102 while fetching 0x20 -> redirect ignored, misalign_err=1 and stays set. Sequence continues 0x24, 0x28.
- stall=1 with ready=0 at pc 0x30; release ready after 2 cycles -> 0x30 accepted, then fetch_valid=0 with fetch_pc=0x34. stall=0 -> fetch_valid=1 at 0x34 next cycle.
- Redirect to 0xFFFFFFFC then two acceptances -> addresses 0xFFFFFFFC then 0x00000000. With FETCH_CNT_EN, fetch_count increments by exactly 1 per acceptance. Asserting rst mid-handshake -> fetch_valid=0 and fetch_pc=RESET_PC immediately.
